cia_6526: RTL and testbench

CIA_6526 -- requirements
Module: cia_6526

---
 rtl/cia_6526_pkg.sv | 85 ++++++++
 rtl/cia_timer.sv | 81 ++++++++
 rtl/cia_6526.sv | 279 +++++++++++++++++++++++++++
 tb/tb_cia_6526.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cia_6526_pkg.sv
// Shared definitions for the 6526 CIA: register map, ICR and control-register bit positions, TOD helpers.
// Latency: none; constants, types and pure functions only.
// Backpressure: none.
package cia_6526_pkg;

    // Register map
    localparam logic [3:0] REG_PRA     = 4'h0;
    localparam logic [3:0] REG_PRB     = 4'h1;
    localparam logic [3:0] REG_DDRA    = 4'h2;
    localparam logic [3:0] REG_DDRB    = 4'h3;
    localparam logic [3:0] REG_TALO    = 4'h4;
    localparam logic [3:0] REG_TAHI    = 4'h5;
    localparam logic [3:0] REG_TBLO    = 4'h6;
    localparam logic [3:0] REG_TBHI    = 4'h7;
    localparam logic [3:0] REG_TOD10   = 4'h8;
    localparam logic [3:0] REG_TODSEC  = 4'h9;
    localparam logic [3:0] REG_TODMIN  = 4'hA;
    localparam logic [3:0] REG_TODHR   = 4'hB;
    localparam logic [3:0] REG_SDR     = 4'hC;
    localparam logic [3:0] REG_ICR     = 4'hD;
    localparam logic [3:0] REG_CRA     = 4'hE;
    localparam logic [3:0] REG_CRB     = 4'hF;

    // ICR bit positions
    localparam int ICR_TA   = 0;
    localparam int ICR_TB   = 1;
    localparam int ICR_ALRM = 2;
    localparam int ICR_SP   = 3;
    localparam int ICR_FLG  = 4;
    localparam int ICR_IR   = 7;

    // CRA/CRB bit positions
    localparam int CR_START      = 0;
    localparam int CR_PBON       = 1;
    localparam int CR_OUTMODE    = 2;
    localparam int CR_RUNMODE    = 3;
    localparam int CR_LOAD       = 4;
    localparam int CRA_INMODE    = 5;
    localparam int CRA_TODIN     = 7;
    localparam int CRB_INMODE_LO = 5;
    localparam int CRB_INMODE_HI = 6;
    localparam int CRB_ALARM     = 7;

    typedef enum logic [1:0] {
        TB_SRC_CLK    = 2'b00,
        TB_SRC_CNT    = 2'b01,
        TB_SRC_TA     = 2'b10,
        TB_SRC_TA_CNT = 2'b11
    } tb_src_e;

    // Time of day in BCD; hr bit7 is PM
    typedef struct packed {
        logic [7:0] hr;
        logic [7:0] min;
        logic [7:0] sec;
        logic [7:0] tenths;
    } tod_t;

    localparam tod_t TOD_RESET = '{hr: 8'h01, min: 8'h00, sec: 8'h00, tenths: 8'h00};

    // BCD increment with wrap 59 -> 00
    function automatic logic [7:0] bcd60_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) r = 8'h00;
            else                r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

    // 12-hour BCD increment: 11 -> 12 flips AM/PM, 12 -> 01
    function automatic logic [7:0] hr_inc(input logic [7:0] v);
        logic [7:0] r;
        logic [4:0] h;
        h = v[4:0];
        if (h == 5'h11)           r = {~v[7], 7'h12};
        else if (h == 5'h12)      r = {v[7], 7'h01};
        else if (h[3:0] == 4'd9)  r = {v[7], 7'h10};
        else                      r = {v[7], 2'b00, h + 5'd1};
        return r;
    endfunction

endpackage

// File: rtl/cia_timer.sv
// Interval timer (TA or TB): 16-bit down counter with reload latch, control register and PB output bit.
// Latency: writes and count ticks act at the next clk edge; uf is combinational in the counting cycle.
// Backpressure: none; every write strobe and tick is consumed in the cycle it is presented.
module cia_timer
    import cia_6526_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic        wr_cr,
    input  logic [7:0]  wr_dat,
    input  logic        tick,
    output logic [15:0] cnt,
    output logic [7:0]  cr,
    output logic        uf,
    output logic        pb_bit
);

    logic [15:0] latch_q, latch_d;
    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  cr_q, cr_d;
    logic        tgl_q, tgl_d;
    logic        pulse_q, pulse_d;
    logic        count_evt;
    logic        force_ld;

    assign force_ld  = wr_cr & wr_dat[CR_LOAD];
    assign count_evt = cr_q[CR_START] & tick;
    // A force load in the same cycle wins over the count, so no underflow is reported then
    assign uf        = count_evt & (cnt_q == 16'h0000) & ~force_ld;

    assign cnt    = cnt_q;
    assign cr     = cr_q;
    assign pb_bit = cr_q[CR_OUTMODE] ? tgl_q : pulse_q;

    // Next-state for latch, counter, control register and PB output state
    always_comb begin
        latch_d = latch_q;
        cnt_d   = cnt_q;
        cr_d    = cr_q;
        tgl_d   = tgl_q;
        pulse_d = uf;

        if (wr_lo) latch_d[7:0]  = wr_dat;
        if (wr_hi) latch_d[15:8] = wr_dat;

        if (force_ld)                         cnt_d = latch_q;
        else if (wr_hi && !cr_q[CR_START])    cnt_d = {wr_dat, latch_q[7:0]};
        else if (uf)                          cnt_d = latch_q;
        else if (count_evt)                   cnt_d = cnt_q - 16'd1;

        // Force-load is a strobe and is never stored
        if (wr_cr) begin
            cr_d          = wr_dat;
            cr_d[CR_LOAD] = 1'b0;
        end
        if (uf && cr_q[CR_RUNMODE]) cr_d[CR_START] = 1'b0;

        if (wr_cr && wr_dat[CR_START] && !cr_q[CR_START]) tgl_d = 1'b1;
        else if (uf)                                      tgl_d = ~tgl_q;
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            latch_q <= 16'hFFFF;
            cnt_q   <= 16'hFFFF;
            cr_q    <= 8'h00;
            tgl_q   <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            latch_q <= latch_d;
            cnt_q   <= cnt_d;
            cr_q    <= cr_d;
            tgl_q   <= tgl_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: rtl/cia_6526.sv
// 6526 CIA: parallel ports, two interval timers, BCD time-of-day clock with alarm, interrupt control.
// Latency: register writes land at the next clk edge; reads are combinational; irq_n lags the flags by one cycle.
// Backpressure: none; the bus is accepted every cycle cs_n is low.
module cia_6526
    import cia_6526_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       rw,
    input  logic [3:0] rs,
    input  logic [7:0] db_in,
    output logic [7:0] db_out,
    input  logic [7:0] pa_in,
    input  logic [7:0] pb_in,
    output logic [7:0] pa_out,
    output logic [7:0] pb_out,
    output logic       irq_n,
    input  logic       flag_n,
    output logic       pc_n,
    input  logic       tod,
    input  logic       sp_in,
    input  logic       cnt_in,
    output logic       sp_out,
    output logic       cnt_out
);

    logic       wr_en, rd_en;
    logic [7:0] pra_q, pra_d, prb_q, prb_d, ddra_q, ddra_d, ddrb_q, ddrb_d, sdr_q, sdr_d;
    logic       pc_q, pc_d;
    logic       flag_prev_q, cnt_prev_q, tod_prev_q;
    logic       flag_fall, cnt_rise, tod_rise;
    logic [4:0] icr_flg_q, icr_flg_d, icr_msk_q, icr_msk_d, icr_evt;
    logic       irq_q, irq_d;
    tod_t       tod_q, tod_d, alm_q, alm_d, todl_q, todl_d, tod_rd;
    logic       todl_vld_q, todl_vld_d, tod_run_q, tod_run_d;
    logic [2:0] tod_div_q, tod_div_d;
    logic       tod_step, alm_match, alm_match_q, alarm_evt;
    logic [15:0] ta_cnt, tb_cnt;
    logic [7:0]  ta_cr, tb_cr;
    logic        ta_uf, tb_uf, ta_pb, tb_pb, ta_tick, tb_tick;
    logic        sp_unused;

    assign wr_en     = ~cs_n & rw;
    assign rd_en     = ~cs_n & ~rw;
    assign flag_fall = flag_prev_q & ~flag_n;
    assign cnt_rise  = cnt_in & ~cnt_prev_q;
    assign tod_rise  = tod & ~tod_prev_q;
    assign sp_unused = sp_in;
    assign sp_out    = 1'b1;
    assign cnt_out   = 1'b1;
    assign irq_n     = irq_q;
    assign pc_n      = pc_q;

    cia_timer u_ta (
        .clk    (clk),
        .reset  (reset),
        .wr_lo  (wr_en && rs == REG_TALO),
        .wr_hi  (wr_en && rs == REG_TAHI),
        .wr_cr  (wr_en && rs == REG_CRA),
        .wr_dat (db_in),
        .tick   (ta_tick),
        .cnt    (ta_cnt),
        .cr     (ta_cr),
        .uf     (ta_uf),
        .pb_bit (ta_pb)
    );

    cia_timer u_tb (
        .clk    (clk),
        .reset  (reset),
        .wr_lo  (wr_en && rs == REG_TBLO),
        .wr_hi  (wr_en && rs == REG_TBHI),
        .wr_cr  (wr_en && rs == REG_CRB),
        .wr_dat (db_in),
        .tick   (tb_tick),
        .cnt    (tb_cnt),
        .cr     (tb_cr),
        .uf     (tb_uf),
        .pb_bit (tb_pb)
    );

    // Timer count sources; TB can chain off TA's underflow in the same cycle
    always_comb begin
        ta_tick = ta_cr[CRA_INMODE] ? cnt_rise : 1'b1;
        case (tb_src_e'(tb_cr[CRB_INMODE_HI:CRB_INMODE_LO]))
            TB_SRC_CLK:    tb_tick = 1'b1;
            TB_SRC_CNT:    tb_tick = cnt_rise;
            TB_SRC_TA:     tb_tick = ta_uf;
            TB_SRC_TA_CNT: tb_tick = ta_uf & cnt_in;
            default:       tb_tick = 1'b0;
        endcase
    end

    // Port registers, data direction, serial data register and PC strobe
    always_comb begin
        pra_d  = pra_q;
        prb_d  = prb_q;
        ddra_d = ddra_q;
        ddrb_d = ddrb_q;
        sdr_d  = sdr_q;
        pc_d   = ~(~cs_n && rs == REG_PRB);
        if (wr_en) begin
            case (rs)
                REG_PRA:  pra_d  = db_in;
                REG_PRB:  prb_d  = db_in;
                REG_DDRA: ddra_d = db_in;
                REG_DDRB: ddrb_d = db_in;
                REG_SDR:  sdr_d  = db_in;
                default:  ;
            endcase
        end
        pa_out    = pra_q | ~ddra_q;
        pb_out    = prb_q | ~ddrb_q;
        if (ta_cr[CR_PBON]) pb_out[6] = ta_pb;
        if (tb_cr[CR_PBON]) pb_out[7] = tb_pb;
    end

    // Interrupt flags: read clears, but an event on the clearing edge survives
    always_comb begin
        icr_evt           = 5'h00;
        icr_evt[ICR_TA]   = ta_uf;
        icr_evt[ICR_TB]   = tb_uf;
        icr_evt[ICR_ALRM] = alarm_evt;
        icr_evt[ICR_FLG]  = flag_fall;
        icr_flg_d = ((rd_en && rs == REG_ICR) ? 5'h00 : icr_flg_q) | icr_evt;
        icr_msk_d = icr_msk_q;
        if (wr_en && rs == REG_ICR) begin
            icr_msk_d = db_in[ICR_IR] ? (icr_msk_q | db_in[4:0]) : (icr_msk_q & ~db_in[4:0]);
        end
        irq_d = ~|(icr_flg_q & icr_msk_q);
    end

    // Time of day: prescaled tenths tick, BCD rollover, set/stop, read latch and alarm match
    always_comb begin
        tod_d      = tod_q;
        alm_d      = alm_q;
        todl_d     = todl_q;
        todl_vld_d = todl_vld_q;
        tod_run_d  = tod_run_q;
        tod_div_d  = tod_div_q;
        tod_step   = 1'b0;

        if (tod_run_q && tod_rise) begin
            if (tod_div_q == (ta_cr[CRA_TODIN] ? 3'd4 : 3'd5)) begin
                tod_div_d = 3'd0;
                tod_step  = 1'b1;
            end else begin
                tod_div_d = tod_div_q + 3'd1;
            end
        end

        if (tod_step) begin
            if (tod_q.tenths == 8'h09) begin
                tod_d.tenths = 8'h00;
                tod_d.sec    = bcd60_inc(tod_q.sec);
                if (tod_q.sec == 8'h59) begin
                    tod_d.min = bcd60_inc(tod_q.min);
                    if (tod_q.min == 8'h59) tod_d.hr = hr_inc(tod_q.hr);
                end
            end else begin
                tod_d.tenths = tod_q.tenths + 8'h01;
            end
        end

        // Writing hours freezes the clock so a full time can be set; tenths restarts it
        if (wr_en) begin
            case (rs)
                REG_TOD10: begin
                    if (tb_cr[CRB_ALARM]) alm_d.tenths = {4'h0, db_in[3:0]};
                    else begin
                        tod_d.tenths = {4'h0, db_in[3:0]};
                        tod_run_d    = 1'b1;
                        tod_div_d    = 3'd0;
                    end
                end
                REG_TODSEC: begin
                    if (tb_cr[CRB_ALARM]) alm_d.sec = {1'b0, db_in[6:0]};
                    else                  tod_d.sec = {1'b0, db_in[6:0]};
                end
                REG_TODMIN: begin
                    if (tb_cr[CRB_ALARM]) alm_d.min = {1'b0, db_in[6:0]};
                    else                  tod_d.min = {1'b0, db_in[6:0]};
                end
                REG_TODHR: begin
                    if (tb_cr[CRB_ALARM]) alm_d.hr = {db_in[7], 2'b00, db_in[4:0]};
                    else begin
                        tod_d.hr  = {db_in[7], 2'b00, db_in[4:0]};
                        tod_run_d = 1'b0;
                    end
                end
                default: ;
            endcase
        end

        // Reading hours snapshots the whole time so a multi-byte read is coherent
        if (rd_en && rs == REG_TODHR && !todl_vld_q) begin
            todl_d     = tod_q;
            todl_vld_d = 1'b1;
        end
        if (rd_en && rs == REG_TOD10) todl_vld_d = 1'b0;

        tod_rd    = todl_vld_q ? todl_q : tod_q;
        alm_match = (tod_q == alm_q);
        alarm_evt = alm_match & ~alm_match_q & tod_run_q;
    end

    // Read data mux; the bus is idle-low so it can be wire-ORed
    always_comb begin
        db_out = 8'h00;
        if (rd_en) begin
            case (rs)
                REG_PRA:    db_out = pa_in;
                REG_PRB:    db_out = pb_in;
                REG_DDRA:   db_out = ddra_q;
                REG_DDRB:   db_out = ddrb_q;
                REG_TALO:   db_out = ta_cnt[7:0];
                REG_TAHI:   db_out = ta_cnt[15:8];
                REG_TBLO:   db_out = tb_cnt[7:0];
                REG_TBHI:   db_out = tb_cnt[15:8];
                REG_TOD10:  db_out = tod_rd.tenths;
                REG_TODSEC: db_out = tod_rd.sec;
                REG_TODMIN: db_out = tod_rd.min;
                REG_TODHR:  db_out = tod_rd.hr;
                REG_SDR:    db_out = sdr_q;
                REG_ICR:    db_out = {|(icr_flg_q & icr_msk_q), 2'b00, icr_flg_q};
                REG_CRA:    db_out = ta_cr;
                REG_CRB:    db_out = tb_cr;
                default:    db_out = 8'h00;
            endcase
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            pra_q       <= 8'h00;
            prb_q       <= 8'h00;
            ddra_q      <= 8'h00;
            ddrb_q      <= 8'h00;
            sdr_q       <= 8'h00;
            pc_q        <= 1'b1;
            flag_prev_q <= 1'b0;
            cnt_prev_q  <= 1'b0;
            tod_prev_q  <= 1'b0;
            icr_flg_q   <= 5'h00;
            icr_msk_q   <= 5'h00;
            irq_q       <= 1'b1;
            tod_q       <= TOD_RESET;
            alm_q       <= '0;
            todl_q      <= '0;
            todl_vld_q  <= 1'b0;
            tod_run_q   <= 1'b1;
            tod_div_q   <= 3'd0;
            alm_match_q <= 1'b0;
        end else begin
            pra_q       <= pra_d;
            prb_q       <= prb_d;
            ddra_q      <= ddra_d;
            ddrb_q      <= ddrb_d;
            sdr_q       <= sdr_d;
            pc_q        <= pc_d;
            flag_prev_q <= flag_n;
            cnt_prev_q  <= cnt_in;
            tod_prev_q  <= tod;
            icr_flg_q   <= icr_flg_d;
            icr_msk_q   <= icr_msk_d;
            irq_q       <= irq_d;
            tod_q       <= tod_d;
            alm_q       <= alm_d;
            todl_q      <= todl_d;
            todl_vld_q  <= todl_vld_d;
            tod_run_q   <= tod_run_d;
            tod_div_q   <= tod_div_d;
            alm_match_q <= alm_match;
        end
    end

endmodule

// File: tb/tb_cia_6526.sv
// Directed testbench for cia_6526: ports, timers, cascade, FLAG interrupt, TOD rollover and alarm.
// Latency: bus accesses take one clock each, driven on the falling edge.
// Backpressure: none; all waits are fixed cycle counts.
module tb_cia_6526;
    import cia_6526_pkg::*;

    logic       clk = 1'b0;
    logic       reset, cs_n, rw, flag_n, tod, sp_in, cnt_in;
    logic [3:0] rs;
    logic [7:0] db_in, pa_in, pb_in;
    logic [7:0] db_out, pa_out, pb_out;
    logic       irq_n, pc_n, sp_out, cnt_out;

    int vectors = 0;
    int miscompares = 0;

    cia_6526 dut (
        .clk(clk), .reset(reset), .cs_n(cs_n), .rw(rw), .rs(rs),
        .db_in(db_in), .db_out(db_out), .pa_in(pa_in), .pb_in(pb_in),
        .pa_out(pa_out), .pb_out(pb_out), .irq_n(irq_n), .flag_n(flag_n),
        .pc_n(pc_n), .tod(tod), .sp_in(sp_in), .cnt_in(cnt_in),
        .sp_out(sp_out), .cnt_out(cnt_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1);
    end

    // All bus tasks start and end on a falling edge
    task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
        cs_n = 1'b0; rw = 1'b1; rs = a; db_in = d;
        @(negedge clk);
        cs_n = 1'b1; rw = 1'b0;
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
        cs_n = 1'b0; rw = 1'b0; rs = a;
        #1 d = db_out;
        @(negedge clk);
        cs_n = 1'b1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [3:0] a [13] = '{REG_TALO, REG_TAHI, REG_TBLO, REG_TBHI, REG_CRA, REG_CRB, REG_ICR,
                               REG_DDRA, REG_SDR, REG_TODHR, REG_TODMIN, REG_TODSEC, REG_TOD10};
        logic [7:0] e [13] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00,
                               8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        logic [7:0] d;
        #1;
        vectors++;
        if ({pa_out, pb_out} !== 16'hFFFF) begin
            miscompares++; $display("FAIL reset_ports got %04h exp FFFF", {pa_out, pb_out});
        end
        vectors++;
        if ({irq_n, pc_n, sp_out, cnt_out} !== 4'b1111) begin
            miscompares++; $display("FAIL reset_pins got %04b exp 1111", {irq_n, pc_n, sp_out, cnt_out});
        end
        vectors++;
        if (db_out !== 8'h00) begin
            miscompares++; $display("FAIL reset_idle_bus got %02h exp 00", db_out);
        end
        for (int i = 0; i < 13; i++) begin
            bus_rd(a[i], d);
            vectors++;
            if (d !== e[i]) begin
                miscompares++; $display("FAIL reset_reg%0h got %02h exp %02h", a[i], d, e[i]);
            end
        end
    endtask

    task automatic test_ports();
        logic [7:0] d;
        bus_wr(REG_DDRA, 8'h0F);
        bus_wr(REG_PRA, 8'h05);
        vectors++;
        if (pa_out !== 8'hF5) begin miscompares++; $display("FAIL pa_out got %02h exp F5", pa_out); end
        pa_in = 8'h3C;
        bus_rd(REG_PRA, d);
        vectors++;
        if (d !== 8'h3C) begin miscompares++; $display("FAIL pra_read got %02h exp 3C", d); end
        bus_rd(REG_DDRA, d);
        vectors++;
        if (d !== 8'h0F) begin miscompares++; $display("FAIL ddra_read got %02h exp 0F", d); end
        bus_wr(REG_DDRB, 8'hFF);
        bus_wr(REG_PRB, 8'hA5);
        vectors++;
        if (pc_n !== 1'b0) begin miscompares++; $display("FAIL pc_after_wr got %b exp 0", pc_n); end
        vectors++;
        if (pb_out !== 8'hA5) begin miscompares++; $display("FAIL pb_out got %02h exp A5", pb_out); end
        idle(1);
        vectors++;
        if (pc_n !== 1'b1) begin miscompares++; $display("FAIL pc_release got %b exp 1", pc_n); end
        pb_in = 8'hC3;
        bus_rd(REG_PRB, d);
        vectors++;
        if (d !== 8'hC3 || pc_n !== 1'b0) begin
            miscompares++; $display("FAIL prb_read got %02h/%b exp C3/0", d, pc_n);
        end
        bus_wr(REG_SDR, 8'h5A);
        bus_rd(REG_SDR, d);
        vectors++;
        if (d !== 8'h5A) begin miscompares++; $display("FAIL sdr got %02h exp 5A", d); end
        // Write cycle must leave the bus at zero
        cs_n = 1'b0; rw = 1'b1; rs = REG_PRA; db_in = 8'h05;
        #1;
        vectors++;
        if (db_out !== 8'h00) begin miscompares++; $display("FAIL bus_in_write got %02h exp 00", db_out); end
        @(negedge clk);
        cs_n = 1'b1; rw = 1'b0;
    endtask

    task automatic test_timer_cont();
        logic [7:0] d;
        logic [7:0] e [8] = '{8'h03, 8'h02, 8'h01, 8'h00, 8'h03, 8'h02, 8'h01, 8'h00};
        bus_rd(REG_ICR, d);
        bus_wr(REG_ICR, 8'h81);
        bus_wr(REG_TALO, 8'h03);
        bus_wr(REG_TAHI, 8'h00);
        bus_wr(REG_CRA, 8'h11);
        for (int i = 0; i < 8; i++) begin
            bus_rd(REG_TALO, d);
            vectors++;
            if (d !== e[i]) begin miscompares++; $display("FAIL ta_count[%0d] got %02h exp %02h", i, d, e[i]); end
        end
        vectors++;
        if (irq_n !== 1'b0) begin miscompares++; $display("FAIL ta_irq got %b exp 0", irq_n); end
        bus_rd(REG_ICR, d);
        vectors++;
        if (d !== 8'h81) begin miscompares++; $display("FAIL ta_icr got %02h exp 81", d); end
        idle(1);
        vectors++;
        if (irq_n !== 1'b1) begin miscompares++; $display("FAIL ta_irq_clear got %b exp 1", irq_n); end
        bus_wr(REG_CRA, 8'h00);
    endtask

    task automatic test_oneshot();
        logic [7:0] d;
        bus_rd(REG_ICR, d);
        bus_wr(REG_CRA, 8'h19);
        idle(6);
        bus_rd(REG_CRA, d);
        vectors++;
        if (d !== 8'h08) begin miscompares++; $display("FAIL oneshot_cra got %02h exp 08", d); end
        bus_rd(REG_TALO, d);
        vectors++;
        if (d !== 8'h03) begin miscompares++; $display("FAIL oneshot_talo got %02h exp 03", d); end
        bus_rd(REG_ICR, d);
        vectors++;
        if (d !== 8'h81) begin miscompares++; $display("FAIL oneshot_icr got %02h exp 81", d); end
        idle(8);
        bus_rd(REG_ICR, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL oneshot_single got %02h exp 00", d); end
        bus_rd(REG_TAHI, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL oneshot_tahi got %02h exp 00", d); end
    endtask

    task automatic test_tb_cascade();
        logic [7:0] d;
        bus_rd(REG_ICR, d);
        bus_wr(REG_TBLO, 8'h01);
        bus_wr(REG_TBHI, 8'h00);
        bus_wr(REG_CRB, 8'h41);
        bus_wr(REG_TALO, 8'h00);
        bus_wr(REG_TAHI, 8'h00);
        bus_wr(REG_CRA, 8'h01);
        for (int i = 0; i < 6; i++) begin
            bus_rd(REG_TBLO, d);
            vectors++;
            if (d !== ((i % 2 == 0) ? 8'h01 : 8'h00)) begin
                miscompares++; $display("FAIL tb_cascade[%0d] got %02h exp %02h", i, d, (i % 2 == 0) ? 8'h01 : 8'h00);
            end
        end
        bus_wr(REG_CRA, 8'h00);
        bus_rd(REG_TBLO, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL tb_hold_a got %02h exp 00", d); end
        idle(2);
        bus_rd(REG_TBLO, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL tb_hold_b got %02h exp 00", d); end
        bus_rd(REG_ICR, d);
        vectors++;
        if (d !== 8'h83) begin miscompares++; $display("FAIL tb_icr got %02h exp 83", d); end
        bus_wr(REG_CRB, 8'h00);
    endtask

    task automatic test_pb_toggle();
        logic [4:0] e = 5'b10011;
        bus_wr(REG_TALO, 8'h01);
        bus_wr(REG_TAHI, 8'h00);
        bus_wr(REG_CRA, 8'h17);
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (pb_out[6] !== e[i]) begin
                miscompares++; $display("FAIL pb6_toggle[%0d] got %b exp %b", i, pb_out[6], e[i]);
            end
            idle(1);
        end
        bus_wr(REG_CRA, 8'h00);
        vectors++;
        if (pb_out !== 8'hA5) begin miscompares++; $display("FAIL pb6_release got %02h exp A5", pb_out); end
    endtask

    task automatic test_flag();
        logic [7:0] d;
        bus_wr(REG_ICR, 8'h1F);
        bus_rd(REG_ICR, d);
        bus_wr(REG_ICR, 8'h90);
        idle(1);
        vectors++;
        if (irq_n !== 1'b1) begin miscompares++; $display("FAIL flag_idle_irq got %b exp 1", irq_n); end
        flag_n = 1'b0;
        idle(3);
        vectors++;
        if (irq_n !== 1'b0) begin miscompares++; $display("FAIL flag_irq got %b exp 0", irq_n); end
        bus_rd(REG_ICR, d);
        vectors++;
        if (d !== 8'h90) begin miscompares++; $display("FAIL flag_icr got %02h exp 90", d); end
        idle(2);
        vectors++;
        if (irq_n !== 1'b1) begin miscompares++; $display("FAIL flag_irq_clear got %b exp 1", irq_n); end
        bus_rd(REG_ICR, d);
        vectors++;
        if (d !== 8'h00) begin miscompares++; $display("FAIL flag_cleared got %02h exp 00", d); end
        flag_n = 1'b1;
        idle(1);
    endtask

    task automatic test_tod();
        logic [7:0] d;
        logic [3:0] a [4] = '{REG_TODHR, REG_TODMIN, REG_TODSEC, REG_TOD10};
        logic [7:0] e [4] = '{8'h92, 8'h00, 8'h00, 8'h00};
        bus_wr(REG_CRB, 8'h80);
        bus_wr(REG_TODHR, 8'h92);
        bus_wr(REG_TODMIN, 8'h00);
        bus_wr(REG_TODSEC, 8'h00);
        bus_wr(REG_TOD10, 8'h00);
        bus_wr(REG_CRB, 8'h00);
        bus_wr(REG_CRA, 8'h80);
        bus_wr(REG_ICR, 8'h84);
        bus_rd(REG_ICR, d);
        bus_wr(REG_TODHR, 8'h11);
        bus_wr(REG_TODMIN, 8'h59);
        bus_wr(REG_TODSEC, 8'h59);
        bus_wr(REG_TOD10, 8'h09);
        for (int i = 0; i < 4; i++) begin
            tod = 1'b1; idle(1); tod = 1'b0; idle(1);
        end
        bus_rd(REG_TOD10, d);
        vectors++;
        if (d !== 8'h09) begin miscompares++; $display("FAIL tod_4edges got %02h exp 09", d); end
        tod = 1'b1; idle(1); tod = 1'b0; idle(2);
        for (int i = 0; i < 4; i++) begin
            bus_rd(a[i], d);
            vectors++;
            if (d !== e[i]) begin miscompares++; $display("FAIL tod_reg%0h got %02h exp %02h", a[i], d, e[i]); end
        end
        bus_rd(REG_ICR, d);
        vectors++;
        if (d !== 8'h84) begin miscompares++; $display("FAIL tod_alarm got %02h exp 84", d); end
    endtask

    initial begin
        reset = 1'b1; cs_n = 1'b1; rw = 1'b0; rs = 4'h0; db_in = 8'h00;
        pa_in = 8'h00; pb_in = 8'h00; flag_n = 1'b1; tod = 1'b0; sp_in = 1'b0; cnt_in = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_ports();
        test_timer_cont();
        test_oneshot();
        test_tb_cascade();
        test_pb_toggle();
        test_flag();
        test_tod();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
